rot_dec_sequencer: RTL and testbench



---
 rtl/rot_dec_sequencer.sv | 84 ++++++++
 tb/tb_rot_dec_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rot_dec_sequencer.sv
// Load/rotate/decode sequencer: captures a 4-bit operand, rotates it right
// rot_cnt times, then offers the value and its MSB-first one-hot decode.
module rot_dec_sequencer #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned OPC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       num_in,
  input  logic [CNT_W-1:0] rot_cnt,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_num,
  output logic [15:0]      out_onehot,
  output logic [OPC_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OPC_W-1:0] op_count_q, op_count_d;

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = num_in;
          cnt_d   = rot_cnt;
          state_d = (rot_cnt == '0) ? OUT : ROT;
        end
      end
      ROT: begin
        work_d = {work_q[0], work_q[3:1]};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          op_count_d = op_count_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      op_count_q <= op_count_d;
    end
  end

  // Outputs decode registered state only; result lines are gated off unless valid.
  always_comb begin
    in_ready   = (state_q == IDLE);
    busy       = (state_q == ROT) || (state_q == OUT);
    out_valid  = (state_q == OUT);
    out_num    = out_valid ? work_q : '0;
    out_onehot = out_valid ? (16'h8000 >> work_q) : '0;
    op_count   = op_count_q;
  end

endmodule

// File: tb/tb_rot_dec_sequencer.sv
// Scoreboard bench for rot_dec_sequencer: expected results are queued at
// start and compared when the DUT presents out_valid.
module tb_rot_dec_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned OPC_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       num_in;
  logic [CNT_W-1:0] rot_cnt;
  logic             in_ready;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_num;
  logic [15:0]      out_onehot;
  logic [OPC_W-1:0] op_count;

  rot_dec_sequencer #(.CNT_W(CNT_W), .OPC_W(OPC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_in     (num_in),
    .rot_cnt    (rot_cnt),
    .in_ready   (in_ready),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_num    (out_num),
    .out_onehot (out_onehot),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  num;
    logic [15:0] onehot;
    int unsigned lat;
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] exp_ops = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [3:0] n, input int unsigned r);
    exp_t e;
    logic [3:0] w;
    w = n;
    for (int unsigned i = 0; i < r; i++) w = {w[0], w[3:1]};
    e.num = w;
    e.onehot = '0;
    e.onehot[15 - w] = 1'b1;
    e.lat = r + 1;
    return e;
  endfunction

  // One operation; ready_wait cycles of backpressure once the result is valid.
  task automatic do_op(input logic [3:0] n, input int unsigned r, input int unsigned ready_wait,
                       input bit verbose);
    int unsigned cyc;
    exp_t e;
    logic [3:0]  held_num;
    logic [15:0] held_oh;
    if (verbose) check("in_ready_pre", in_ready, 1);
    start = 1'b1; num_in = n; rot_cnt = CNT_W'(r); out_ready = (ready_wait == 0);
    sb_q.push_back(model(n, r));
    tick();
    start = 1'b0; num_in = ~n;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!out_valid) begin
      check("valid_timeout", 0, 1);
      void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    check("latency", cyc, e.lat);
    check("out_num", out_num, e.num);
    check("out_onehot", out_onehot, e.onehot);
    if (verbose) begin
      check("busy_out", busy, 1);
      check("in_ready_out", in_ready, 0);
    end
    held_num = out_num;
    held_oh  = out_onehot;
    for (int unsigned i = 0; i < ready_wait; i++) begin
      start = 1'b1; num_in = 4'(i + 3); rot_cnt = '0;
      tick();
      check("bp_num", out_num, held_num);
      check("bp_onehot", out_onehot, held_oh);
      check("bp_in_ready", in_ready, 0);
      check("bp_op_count", op_count, exp_ops);
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    exp_ops = exp_ops + 1'b1;
    out_ready = 1'b0;
    check("op_count", op_count, exp_ops);
    if (verbose) begin
      check("in_ready_post", in_ready, 1);
      check("valid_post", out_valid, 0);
      check("busy_post", busy, 0);
      check("onehot_gated", out_onehot, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_in = '0; rot_cnt = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_num", out_num, 0);
    check("rst_onehot", out_onehot, 0);
    check("rst_op_count", op_count, 0);

    do_op(4'h8, 1, 0, 1'b1);
    do_op(4'hF, 0, 0, 1'b1);
    do_op(4'h6, 4, 0, 1'b1);
    do_op(4'h3, 5, 0, 1'b1);
    do_op(4'hA, 15, 0, 1'b1);
    do_op(4'h5, 2, 5, 1'b1);
    // The dropped start must not have started anything.
    tick();
    check("no_dropped_op", busy, 0);

    // Reset in cycle 4 of a long rotation.
    start = 1'b1; num_in = 4'h1; rot_cnt = 4'd15; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("mid_rot_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ops = '0;
    check("mrst_state", in_ready, 1);
    check("mrst_valid", out_valid, 0);
    check("mrst_onehot", out_onehot, 0);
    check("mrst_op_count", op_count, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (out_valid) seen++;
      end
      check("mrst_no_result", seen, 0);
    end

    // rst beats start on the same edge.
    rst = 1'b1; start = 1'b1; num_in = 4'h7; rot_cnt = '0;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_idle", in_ready, 1);
    check("rst_start_busy", busy, 0);

    // 256 zero-rotation operations to wrap op_count.
    for (int unsigned k = 1; k <= 256; k++) begin
      do_op(4'(k * 7), 0, 0, 1'b0);
      if (k == 255) check("op_count_255", op_count, 255);
      if (k == 256) check("op_count_wrap", op_count, 0);
    end

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
